// File: rtl/ff_pkg.sv
// ff_pkg: GF(2^M) constants, FSM states and helpers shared by
// the multiplier and the divider/inverter datapaths.
package ff_pkg;

    localparam int         FF_M    = 8;
    localparam logic [8:0] FF_POLY = 9'h11B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ff_state_e;

    // Generic multiply-by-x for any degree up to 16
    function automatic logic [15:0] ff_xtime(
        input logic [15:0] v,
        input logic [16:0] poly,
        input int          m
    );
        logic [15:0] mask;
        logic [15:0] r;
        mask = 16'((32'd1 << m) - 32'd1);
        r    = (v << 1) & mask;
        if (v[m-1])
            r = r ^ (poly[15:0] & mask);
        return r;
    endfunction

endpackage

// File: rtl/ff_xtime.sv
// ff_xtime: combinational multiply-by-x in GF(2^M) with
// reduction by POLY.
module ff_xtime
    import ff_pkg::*;
#(
    parameter int         M    = FF_M,
    parameter logic [M:0] POLY = FF_POLY
) (
    input  logic [M-1:0] v,
    output logic [M-1:0] y
);

    assign y = {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY[M-1:0] : '0);

endmodule

// File: rtl/ff_mul_seq.sv
// ff_mul_seq: bit-serial GF(2^M) multiplier, MSB-first Horner
// evaluation, one multiplier bit per cycle, valid/ready on both sides.
module ff_mul_seq
    import ff_pkg::*;
#(
    parameter int         M    = FF_M,
    parameter logic [M:0] POLY = FF_POLY
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] product,
    output logic         busy
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    if ((M < 2) || (M > 16) || (POLY[M] != 1'b1)) begin : g_bad_param
        $error("ff_mul_seq: M must be 2..16 and POLY[M] must be 1");
    end

    ff_state_e     state;
    logic [M-1:0]  a_reg;
    logic [M-1:0]  b_reg;
    logic [M-1:0]  acc;
    logic [M-1:0]  acc_x;
    logic [M-1:0]  acc_nxt;
    logic [CW-1:0] cnt;

    ff_xtime #(
        .M    (M),
        .POLY (POLY)
    ) u_xtime (
        .v (acc),
        .y (acc_x)
    );

    assign acc_nxt   = acc_x ^ (b_reg[cnt] ? a_reg : '0);
    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= CW'(M - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    // Last bit: publish the freshly reduced accumulator
                    if (cnt == '0) begin
                        product <= acc_nxt;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_mul_seq.sv
// tb_ff_mul_seq: randomized and directed checks of ff_mul_seq
// against a carry-less-multiply-then-reduce reference model.
module tb_ff_mul_seq;

    localparam int         M    = 8;
    localparam logic [8:0] POLY = 9'h11B;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ff_mul_seq #(
        .M    (M),
        .POLY (POLY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Schoolbook carry-less product, then long-division reduction
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'(POLY) << (i - 8));
        return p[7:0];
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (!out_valid && cyc < 50) begin
            if (busy) nbusy++;
            tick();
            cyc++;
        end
        if (!out_valid) cyc = -1;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #12;
        n_cmp++;
        if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_state: rdy/vld/busy/prod=%b/%b/%b/%h required 1/0/0/00",
                     in_ready, out_valid, busy, product);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_known;
        logic [7:0] tv [5][3];
        int cyc;
        int nb;
        tv[0] = '{8'h57, 8'h83, 8'hC1};
        tv[1] = '{8'h57, 8'h13, 8'hFE};
        tv[2] = '{8'h53, 8'hCA, 8'h01};
        tv[3] = '{8'h00, 8'hFF, 8'h00};
        tv[4] = '{8'h01, 8'hB6, 8'hB6};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(tv[i][0], tv[i][1]);
            wait_done(cyc, nb);
            n_cmp++;
            if (cyc !== M || nb !== M) begin
                n_bad++;
                $display("FAIL known_latency[%0d]: latency=%0d busy=%0d required %0d/%0d",
                         i, cyc, nb, M, M);
            end
            n_cmp++;
            if (product !== tv[i][2]) begin
                n_bad++;
                $display("FAIL known_product[%0d]: %h*%h got %h required %h",
                         i, tv[i][0], tv[i][1], product, tv[i][2]);
            end
            tick();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL known_idle[%0d]: in_ready=%b out_valid=%b required 1/0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] exp;
        int cyc;
        int nb;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x   = 8'($urandom);
            y   = 8'($urandom);
            exp = gmul(x, y);
            issue(x, y);
            wait_done(cyc, nb);
            n_cmp++;
            if (cyc !== M || product !== exp) begin
                n_bad++;
                $display("FAIL random[%0d]: %h*%h got %h lat %0d required %h lat %0d",
                         i, x, y, product, cyc, exp, M);
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        int nb;
        out_ready = 1'b0;
        issue(8'h57, 8'h83);
        wait_done(cyc, nb);
        for (int i = 0; i < 5; i++) begin
            a        = 8'($urandom);
            b        = 8'($urandom);
            in_valid = 1'b1;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || product !== 8'hC1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: vld=%b prod=%h rdy=%b required 1/c1/0",
                         i, out_valid, product, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: vld=%b rdy=%b busy=%b required 0/1/0",
                     out_valid, in_ready, busy);
        end
        issue(8'h02, 8'h87);
        wait_done(cyc, nb);
        n_cmp++;
        if (cyc !== M || product !== gmul(8'h02, 8'h87)) begin
            n_bad++;
            $display("FAIL bp_next: got %h lat %0d required %h lat %0d",
                     product, cyc, gmul(8'h02, 8'h87), M);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int seen;
        int cyc;
        int nb;
        out_ready = 1'b1;
        issue(8'h57, 8'h83);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_mid: rdy/vld/busy/prod=%b/%b/%b/%h required 1/0/0/00",
                     in_ready, out_valid, busy, product);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_no_valid: out_valid cycles=%0d required 0", seen);
        end
        issue(8'h57, 8'h83);
        wait_done(cyc, nb);
        n_cmp++;
        if (cyc !== M || product !== 8'hC1) begin
            n_bad++;
            $display("FAIL reset_recover: got %h lat %0d required c1 lat %0d",
                     product, cyc, M);
        end
        tick();
    endtask

    // Quotient x/y found by exhaustive search, then q*y must give x
    task automatic test_divider_sweep;
        logic [7:0] x;
        logic [7:0] q;
        int cyc;
        int nb;
        x         = 8'h0B;
        out_ready = 1'b1;
        for (int y = 1; y < 256; y++) begin
            q = '0;
            for (int c = 0; c < 256; c++)
                if (gmul(8'(c), 8'(y)) == x) q = 8'(c);
            issue(q, 8'(y));
            wait_done(cyc, nb);
            n_cmp++;
            if (cyc !== M || product !== x) begin
                n_bad++;
                $display("FAIL div_sweep[%0d]: q=%h got %h lat %0d required %h lat %0d",
                         y, q, product, cyc, x, M);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_divider_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
